// File: rtl/cond_pkg.sv
// Shared types and constants for the conditional-execution stage:
// ARM condition codes, NZCV bit positions and FlagW encodings.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [1:0] FLAGW_NZ  = 2'b10;
  localparam logic [1:0] FLAGW_ALL = 2'b11;

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluation: instruction condition field against
// the registered NZCV flags.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n;
  logic z;
  logic c;
  logic v;

  assign n = Flags[FLAG_N];
  assign z = Flags[FLAG_Z];
  assign c = Flags[FLAG_C];
  assign v = Flags[FLAG_V];

  always_comb begin
    CondEx = 1'b0;
    case (cond_e'(Cond))
      EQ: CondEx = z;
      NE: CondEx = !z;
      CS: CondEx = c;
      CC: CondEx = !c;
      MI: CondEx = n;
      PL: CondEx = !n;
      VS: CondEx = v;
      VC: CondEx = !v;
      HI: CondEx = c & !z;
      LS: CondEx = !c | z;
      GE: CondEx = (n == v);
      LT: CondEx = (n != v);
      GT: CondEx = !z & (n == v);
      LE: CondEx = z | (n != v);
      AL: CondEx = 1'b1;
      NV: CondEx = 1'b0; // never-execute
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution stage: NZCV flag register, condition check and
// write-strobe gating. COND_PERF_CNT_EN adds saturating exec/skip counters.
module cond_logic
  import cond_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             CondEx,
  output logic [3:0]       Flags
`ifdef COND_PERF_CNT_EN
  ,
  input  logic             CntClr,
  output logic [CNT_W-1:0] ExecCount,
  output logic [CNT_W-1:0] SkipCount
`endif
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("cond_logic: CNT_W must be at least 1");
  end

  logic retire;
  logic flag_we_nz;
  logic flag_we_cv;

  cond_check u_cond_check (
    .Cond   (Cond),
    .Flags  (Flags),
    .CondEx (CondEx)
  );

  // Evaluated against the current (old) flags; a flag write lands at the edge.
  assign retire     = en & CondEx;
  assign flag_we_nz = retire & ((FlagW & FLAGW_NZ) != 2'b00);
  assign flag_we_cv = retire & ((FlagW & (FLAGW_ALL ^ FLAGW_NZ)) != 2'b00);

  assign PCSrc    = rst_n & retire & PCS;
  assign RegWrite = rst_n & retire & RegW & !NoWrite;
  assign MemWrite = rst_n & retire & MemW;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Flags <= 4'b0000;
    end else begin
      if (flag_we_nz) Flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
      if (flag_we_cv) Flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
    end
  end

`ifdef COND_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (!rst_n || CntClr) begin
      ExecCount <= '0;
      SkipCount <= '0;
    end else if (en) begin
      if (CondEx) begin
        if (ExecCount != CNT_MAX) ExecCount <= ExecCount + CNT_W'(1);
      end else begin
        if (SkipCount != CNT_MAX) SkipCount <= SkipCount + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_cond_logic.sv
// Bench for cond_logic: directed and random stimulus against a reference
// model, with a negedge monitor popping expected outputs from a queue.
module tb_cond_logic;
  import cond_pkg::*;

  localparam int TB_CNT_W = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       NoWrite;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic       CondEx;
  logic [3:0] Flags;
  logic       CntClr;
`ifdef COND_PERF_CNT_EN
  logic [TB_CNT_W-1:0] ExecCount;
  logic [TB_CNT_W-1:0] SkipCount;
`endif

  int checks = 0;
  int passes = 0;
  int cycle  = 0;

  logic [7:0]            exp_q[$];
  logic [2*TB_CNT_W-1:0] cnt_q[$];

  // Reference model state: flags visible this cycle and counter values.
  logic [3:0] m_flags = 4'b0000;
  int         m_exec  = 0;
  int         m_skip  = 0;
  int         cnt_max = (1 << TB_CNT_W) - 1;

  always #5 clk = ~clk;

`ifdef COND_PERF_CNT_EN
  cond_logic #(.CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .Cond(Cond), .ALUFlags(ALUFlags),
    .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
    .Flags(Flags), .CntClr(CntClr), .ExecCount(ExecCount), .SkipCount(SkipCount)
  );
`else
  cond_logic dut (
    .clk(clk), .rst_n(rst_n), .en(en), .Cond(Cond), .ALUFlags(ALUFlags),
    .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
    .Flags(Flags)
  );
`endif

  // ARM encoding: bits [3:1] pick a base predicate, bit 0 inverts it.
  // Pair 7 is AL (base true) / NV (inverted, never executes).
  function automatic logic model_pass(input logic [3:0] c_f, input logic [3:0] f);
    logic n, z, c, v, base;
    {n, z, c, v} = f;
    case (c_f[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c && !z;
      3'd5:    base = (n == v);
      3'd6:    base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c_f[0] ? !base : base;
  endfunction

  task automatic step(input logic r, input logic e, input logic [3:0] c_f,
                      input logic [3:0] af, input logic [1:0] fw,
                      input logic pcs_i, input logic regw_i, input logic memw_i,
                      input logic nowr_i, input logic clr_i);
    logic       pass;
    logic [7:0] exp;
    @(posedge clk);
    #1;
    rst_n = r; en = e; Cond = c_f; ALUFlags = af; FlagW = fw;
    PCS = pcs_i; RegW = regw_i; MemW = memw_i; NoWrite = nowr_i; CntClr = clr_i;
    cycle++;
    pass = model_pass(c_f, m_flags);
    exp = {r && e && pass && pcs_i, r && e && pass && regw_i && !nowr_i,
           r && e && pass && memw_i, pass, m_flags};
    exp_q.push_back(exp);
    cnt_q.push_back({m_exec[TB_CNT_W-1:0], m_skip[TB_CNT_W-1:0]});
    // Advance the model across the coming edge.
    if (!r) begin
      m_flags = 4'b0000;
    end else if (e && pass) begin
      if (fw[1]) m_flags[3:2] = af[3:2];
      if (fw[0]) m_flags[1:0] = af[1:0];
    end
    if (!r || clr_i) begin
      m_exec = 0;
      m_skip = 0;
    end else if (e) begin
      if (pass) m_exec = (m_exec < cnt_max) ? m_exec + 1 : cnt_max;
      else      m_skip = (m_skip < cnt_max) ? m_skip + 1 : cnt_max;
    end
  endtask

  always @(negedge clk) begin
    logic [7:0]            exp, got;
    logic [2*TB_CNT_W-1:0] exp_cnt;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      exp_cnt = cnt_q.pop_front();
      got = {PCSrc, RegWrite, MemWrite, CondEx, Flags};
      checks++;
      if (got !== exp)
        $display("FAIL outputs cycle %0d: got {PCSrc,RegWrite,MemWrite,CondEx,Flags}=%b expected %b",
                 cycle, got, exp);
      else
        passes++;
`ifdef COND_PERF_CNT_EN
      checks++;
      if ({ExecCount, SkipCount} !== exp_cnt)
        $display("FAIL counters cycle %0d: got exec=%0d skip=%0d expected exec=%0d skip=%0d",
                 cycle, ExecCount, SkipCount, exp_cnt[2*TB_CNT_W-1:TB_CNT_W],
                 exp_cnt[TB_CNT_W-1:0]);
      else
        passes++;
`endif
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; Cond = 4'b0000; ALUFlags = 4'b0000; FlagW = 2'b00;
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0; CntClr = 1'b0;

    // Reset, then AL retires a register write; EQ fails on cleared flags.
    step(0, 0, AL, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
    step(1, 1, AL, 4'b0000, 2'b00, 0, 1, 0, 0, 0);
    step(1, 1, EQ, 4'b0000, 2'b00, 0, 1, 0, 0, 0);
    step(1, 1, NE, 4'b0000, 2'b00, 1, 1, 1, 0, 0);
    // Flag write, then EQ in the next cycle sees Z.
    step(1, 1, AL, 4'b0100, FLAGW_ALL, 0, 0, 0, 0, 0);
    step(1, 1, EQ, 4'b0000, 2'b00, 1, 0, 0, 0, 0);
    // Logical-op write keeps C and V; NoWrite blocks the register write.
    step(1, 1, AL, 4'b1111, FLAGW_ALL, 0, 0, 0, 0, 0);
    step(1, 1, AL, 4'b0000, FLAGW_NZ, 0, 0, 0, 0, 0);
    step(1, 1, AL, 4'b0000, 2'b00, 0, 1, 0, 1, 0);
    // Failed condition must not write flags or memory.
    step(0, 0, AL, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
    step(1, 1, EQ, 4'b1111, FLAGW_ALL, 0, 0, 1, 0, 0);
    step(1, 1, AL, 4'b0000, 2'b00, 0, 0, 1, 0, 0);
    // Stall ignores flag writes and strobes.
    step(1, 0, AL, 4'b1010, FLAGW_ALL, 1, 1, 1, 0, 0);
    step(1, 1, AL, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
    // Reset beats a flag write on the same edge.
    step(1, 1, AL, 4'b1111, FLAGW_ALL, 0, 0, 0, 0, 0);
    step(0, 1, AL, 4'b0101, FLAGW_ALL, 1, 1, 1, 0, 0);
    step(1, 1, NE, 4'b0000, 2'b00, 1, 0, 0, 0, 0);
    // Counters: clear, saturate exec, one skip, clear together with en.
    step(1, 1, AL, 4'b0000, 2'b00, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 1, AL, 4'b0000, 2'b00, 0, 1, 0, 0, 0);
    step(1, 1, NV, 4'b0000, 2'b00, 0, 1, 0, 0, 0);
    step(1, 1, AL, 4'b0000, 2'b00, 0, 0, 0, 0, 1);
    step(1, 0, AL, 4'b0000, 2'b00, 0, 0, 0, 0, 0);

    // Every condition against every flag combination.
    for (int f = 0; f < 16; f++) begin
      step(1, 1, AL, 4'(f), FLAGW_ALL, 0, 0, 0, 0, 0);
      for (int c = 0; c < 16; c++) step(1, 1, 4'(c), 4'b0000, 2'b00, 1, 1, 1, 0, 0);
    end

    // Random traffic with occasional resets, stalls and clears.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 39) != 0, $urandom_range(0, 3) != 0,
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0)
      $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
    else
      passes++;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cond_logic.md
# cond_logic

Conditional-execution stage for the ARMv4 core. It sits directly downstream of the ALU decoder and the ALU: it consumes the decoder's `FlagW` and the ALU's `ALUFlags`, holds the architectural NZCV flag register, and evaluates the instruction's condition field. From that result it gates the PC, register-file and memory write strobes. Optional saturating performance counters tally executed and skipped instructions.

## Interface
Parameters:
- `CNT_W`, default 32: width of each performance counter. Used only with `COND_PERF_CNT_EN`.

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  reset, synchronous and active-low.
- `en`  in  1  the instruction on the inputs retires this cycle. When 0, the stage is stalled.
- `Cond`  in  4  instruction condition field, bits [31:28].
- `ALUFlags`  in  4  ALU result flags {N,Z,C,V}.
- `FlagW`  in  2  flag-write request from the ALU decoder. [1] requests an N,Z write; [0] requests a C,V write.
- `PCS`  in  1  raw PC-write request.
- `RegW`  in  1  raw register-write request.
- `MemW`  in  1  raw memory-write request.
- `NoWrite`  in  1  suppresses the register write (CMP/TST class).
- `PCSrc`  out  1  gated PC write.
- `RegWrite`  out  1  gated register write.
- `MemWrite`  out  1  gated memory write.
- `CondEx`  out  1  condition passed.
- `Flags`  out  4  current registered {N,Z,C,V}.
- `CntClr`  in  1  synchronous counter clear. Present only with the macro.
- `ExecCount`  out  CNT_W  count of executed instructions. Present only with the macro.
- `SkipCount`  out  CNT_W  count of condition-failed instructions. Present only with the macro.

## Operation
- `CondEx` is combinational from `Cond` and the **registered** `Flags`:
  - EQ 0000: Z
  - NE 0001: !Z
  - CS 0010: C
  - CC 0011: !C
  - MI 0100: N
  - PL 0101: !N
  - VS 0110: V
  - VC 0111: !V
  - HI 1000: C&!Z
  - LS 1001: !C|Z
  - GE 1010: N==V
  - LT 1011: N!=V
  - GT 1100: !Z&(N==V)
  - LE 1101: Z|(N!=V)
  - AL 1110: 1
  - NV 1111: 0. NV is defined as never-execute.
- Write-strobe gating:
  - `PCSrc` = `en & CondEx & PCS`
  - `RegWrite` = `en & CondEx & RegW & !NoWrite`
  - `MemWrite` = `en & CondEx & MemW`
  - While `rst_n`=0, all three are forced to 0.
- Flag register update:
  - `Flags[3:2]` ← `ALUFlags[3:2]` when `en & CondEx & FlagW[1]`.
  - `Flags[1:0]` ← `ALUFlags[1:0]` when `en & CondEx & FlagW[0]`.
  - Otherwise each half holds its value.
  - The two halves update independently. FlagW=10 (logical ops) preserves C and V.
- A failed condition updates no flags, whatever the value of `FlagW`.

## Timing
- `CondEx` and the write strobes are zero-latency (combinational) from their inputs.
- `Flags` updates at the rising edge and is visible in the next cycle.
  - An instruction retiring in the same cycle as a flag write is evaluated against the old flags.
  - The next instruction sees the new flags. No bypass.
- Reset: `Flags`=0000.
  - After reset, EQ fails, NE passes, and AL passes.
- If `rst_n`=0 at an edge, reset wins over any `en` or flag write.
- Reset mid-stall clears `Flags`. No pending update survives reset.
- With `en`=0, `Flags` holds for any `FlagW`/`ALUFlags` values, and no write strobe asserts.

## Configuration
- Macro `COND_PERF_CNT_EN`.
- **Defined:**
  - `CntClr`, `ExecCount` and `SkipCount` exist.
  - On each `en` cycle, `ExecCount` increments if `CondEx`=1; otherwise `SkipCount` increments.
  - Counters saturate at all-ones.
  - `CntClr` clears both counters synchronously and has priority over the increment in the same cycle.
  - Both counters reset to 0.
- **Undefined:** these ports and registers are absent, and the remaining behaviour is identical.

## Structure
- Package `cond_pkg` holds:
  - enum `cond_e`: the 16 condition codes, EQ..NV.
  - flag index constants `FLAG_N`=3, `FLAG_Z`=2, `FLAG_C`=1, `FLAG_V`=0.
  - `FLAGW_NZ`=2'b10 and `FLAGW_ALL`=2'b11.
- One natural sub-module, `cond_check`: combinational `Cond` + `Flags` → `CondEx`.
- The flag register, strobe gating and counters live in `cond_logic`.

## Test plan
- Reset, then Cond=AL, RegW=1, en=1 → RegWrite=1, Flags=0000. Cond=EQ → CondEx=0, RegWrite=0.
- FlagW=11, ALUFlags=0100, Cond=AL, en=1 for one cycle; next cycle Cond=EQ, PCS=1 → Flags=0100, PCSrc=1.
- Flags=1111, then FlagW=10, ALUFlags=0000 → Flags=0011. C and V are preserved.
- Flags=0000, Cond=EQ, FlagW=11, ALUFlags=1111 → no update (Flags=0000) and MemWrite=0 with MemW=1.
- en=0 with FlagW=11, ALUFlags=1010 → Flags unchanged and all strobes 0. rst_n=0 on the same edge as a flag write → Flags=0000.
- With macro, CNT_W=2: 5 passing en cycles → ExecCount=3 (saturated). One failing cycle → SkipCount=1. CntClr together with en → both counters 0.
